image_window_ctrl: RTL and testbench
====================================

Name: image_window_ctrl

Overview:
Producer side of the 3x3 window interface consumed by the gaussian blur stage. It accepts a raster pixel stream one byte per beat and stores it in four rotating line buffers. It emits one 72-bit 3x3 window per cycle on pixel_data/pixel_data_valid, with one pulse per completed output row. Three buffers are read while the fourth is written, so input and output overlap.

Parameters:
IMG_WIDTH, 512, pixels per image line; legal range is 4 or more.
CNT_W, $clog2(4*IMG_WIDTH+1), width of the fill counter (derived, not overridden).

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  synchronous active-low reset
in_pixel  in  8  input pixel, raster order
in_pixel_valid  in  1  in_pixel valid this cycle
in_ready  out  1  block can accept a pixel; a beat is accepted when in_pixel_valid and in_ready are both high
pixel_data  out  72  3x3 window; byte i = pixel_data[i*8+:8]; bytes 0-2 top row left to right, 3-5 middle row, 6-8 bottom row
pixel_data_valid  out  1  pixel_data holds a valid window this cycle
line_done_intr  out  1  one-cycle pulse when an output row is complete and its top line is released

Behaviour:
- Reset (rst_n low at a clk edge) sets:
  - wr_col=0, wr_idx=0, rd_col=0, rd_idx=0, fill=0, FSM=IDLE;
  - pixel_data=0, pixel_data_valid=0, line_done_intr=0;
  - in_ready=1 in the first cycle after reset.
  - Line buffer contents are not cleared.
- Reset mid-operation: any partial line and any in-flight window are discarded. The next cycle behaves as a fresh frame.
- Write side:
  - An accepted beat writes buffer[wr_idx][wr_col] and increments wr_col.
  - When wr_col = IMG_WIDTH-1, wr_col wraps to 0 and wr_idx becomes (wr_idx+1) mod 4.
  - Gaps in in_pixel_valid are allowed and leave all write state unchanged.
- in_ready = (fill < 4*IMG_WIDTH), decoded from registered fill. Beats presented while in_ready is low are dropped with no state change.
- fill counter:
  - +1 per accepted beat.
  - -IMG_WIDTH on each line release.
  - Both in the same cycle: fill = fill + 1 - IMG_WIDTH.
  - fill never exceeds 4*IMG_WIDTH and never goes negative.
- FSM has two states, IDLE and RD:
  - IDLE -> RD at an edge where registered fill >= 3*IMG_WIDTH.
  - In RD, one window read is issued every cycle (no stall) for rd_col = 0 .. IMG_WIDTH-3, giving IMG_WIDTH-2 windows per row with no edge padding.
  - After the read at rd_col = IMG_WIDTH-3: rd_col returns to 0, rd_idx becomes (rd_idx+1) mod 4, fill is decremented by IMG_WIDTH (release), and FSM returns to IDLE. At least one IDLE cycle separates rows.
- Window composition for a read at column c:
  - top row = buffer[rd_idx] columns c, c+1, c+2;
  - middle row = buffer[(rd_idx+1) mod 4], same columns;
  - bottom row = buffer[(rd_idx+2) mod 4], same columns.
- Latency: window bytes and valid are registered. A read issued in cycle t drives pixel_data and pixel_data_valid=1 in cycle t+1.
  - From the 3*IMG_WIDTH-th accepted beat (edge E0), the first valid window appears in the cycle after edge E0+2.
- pixel_data holds its last value when valid is low.
- line_done_intr is registered and is high in the same cycle as the row's last valid window.
- The writer never overwrites a line being read: the fill cap guarantees the writer only targets the free fourth buffer.

Decomposition:
- Shared package (image_pkg):
  - PIX_W=8;
  - WIN_TAPS=9;
  - NUM_LINE_BUFS=4;
  - FSM state enum {IDLE, RD};
  - window byte-order constants (row offsets 0, 3, 6).
- Sub-module line_buffer (parameter IMG_WIDTH):
  - one write port (wr_en, wr_data, wr_col);
  - a combinational 24-bit read of columns c..c+2 at rd_col.
  - Instantiated 4 times.
- Top level holds the counters, the FSM, the rd_idx rotation mux and the output registers.

Test Plan (IMG_WIDTH=8):
1. Hold rst_n low 2 cycles -> pixel_data=0, pixel_data_valid=0, line_done_intr=0, in_ready=1.
2. Stream values 0..23 on consecutive cycles -> 6 consecutive valid windows.
   - First window: bytes 0..8 = 0,1,2,8,9,10,16,17,18.
   - Last window: 5,6,7,13,14,15,21,22,23.
   - line_done_intr pulses exactly once, on the 6th valid cycle; valid then low for at least 1 cycle.
3. Stream 0..39 continuously -> 18 windows total.
   - Row 3 uses wrapped buffers 2,3,0; its first window = 16,17,18,24,25,26,32,33,34.
   - in_ready stays 1 throughout.
4. Stream 0..23 with in_pixel_valid toggling 1,0,1,0 -> same windows as test 2. First valid exactly 2 cycles after the edge accepting value 23.
5. Drive a write in the same cycle as a row release -> fill changes by +1-8 (e.g. 25 -> 18 in the next cycle). No window corruption.
6. Pull rst_n low during the 3rd window of a row -> valid=0 and fill=0 next cycle. Fresh stream 100..123 then yields first window 100,101,102,108,109,110,116,117,118.

Source files
------------

// File: rtl/image_pkg.sv
// Shared constants and types for the 3x3 window producer: pixel and window
// widths, line-buffer count, read FSM states and window byte layout.
package image_pkg;

    localparam int PIX_W         = 8;
    localparam int WIN_TAPS      = 9;
    localparam int NUM_LINE_BUFS = 4;
    localparam int ROW_TAPS      = 3;
    localparam int ROW_W         = ROW_TAPS * PIX_W;
    localparam int WIN_W         = WIN_TAPS * PIX_W;

    // Byte offset of each window row inside pixel_data.
    localparam int ROW_TOP_OFS = 0;
    localparam int ROW_MID_OFS = 3;
    localparam int ROW_BOT_OFS = 6;

    typedef enum logic {
        IDLE = 1'b0,
        RD   = 1'b1
    } rd_state_t;

    typedef logic [1:0] buf_idx_t;

endpackage

// File: rtl/image_window_ctrl_line_buffer.sv
// One image line of storage: single write port, plus a combinational read
// of three adjacent pixels (columns c, c+1, c+2) for one window row.
module line_buffer
    import image_pkg::*;
#(
    parameter int IMG_WIDTH = 512
) (
    input  logic                         clk,
    input  logic                         wr_en,
    input  logic [PIX_W-1:0]             wr_data,
    input  logic [$clog2(IMG_WIDTH)-1:0] wr_col,
    input  logic [$clog2(IMG_WIDTH)-1:0] rd_col,
    output logic [ROW_W-1:0]             rd_data
);

    localparam int COL_W = $clog2(IMG_WIDTH);

    logic [PIX_W-1:0] mem [IMG_WIDTH];
    logic [COL_W-1:0] col1;
    logic [COL_W-1:0] col2;

    // Store one accepted pixel at its column.
    // NOTE: the storage array has no reset; every location is written before
    // it is read, and clearing it would only stop it mapping onto RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_col] <= wr_data;
        end
    end

    // Neighbour columns, clamped so the index never leaves the array even
    // when rd_col sits past the last legal window start.
    always_comb begin
        col1 = rd_col;
        col2 = rd_col;
        if (rd_col < COL_W'(IMG_WIDTH - 1)) col1 = rd_col + COL_W'(1);
        if (rd_col < COL_W'(IMG_WIDTH - 2)) col2 = rd_col + COL_W'(2);
    end

    // Leftmost pixel lands in the lowest byte.
    assign rd_data = {mem[col2], mem[col1], mem[rd_col]};

endmodule

// File: rtl/image_window_ctrl.sv
// Producer side of the 3x3 window interface. Raster pixels are written into
// four rotating line buffers; once three full lines are held, one window per
// cycle is emitted for each row while the fourth buffer keeps filling.
module image_window_ctrl
    import image_pkg::*;
#(
    parameter int IMG_WIDTH = 512
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PIX_W-1:0] in_pixel,
    input  logic             in_pixel_valid,
    output logic             in_ready,
    output logic [WIN_W-1:0] pixel_data,
    output logic             pixel_data_valid,
    output logic             line_done_intr
);

    localparam int CNT_W = $clog2(4 * IMG_WIDTH + 1);
    localparam int COL_W = $clog2(IMG_WIDTH);

    rd_state_t        state;
    rd_state_t        next_state;
    logic [COL_W-1:0] wr_col;
    logic [COL_W-1:0] rd_col;
    buf_idx_t         wr_idx;
    buf_idx_t         rd_idx;
    logic [CNT_W-1:0] fill;

    logic             accept;
    logic             rd_issue;
    logic             rd_last;
    logic [WIN_W-1:0] win_next;
    logic [ROW_W-1:0] row_data [NUM_LINE_BUFS];

    assign in_ready = (fill < CNT_W'(4 * IMG_WIDTH));
    assign accept   = in_pixel_valid && in_ready;

    for (genvar b = 0; b < NUM_LINE_BUFS; b++) begin : g_buf
        line_buffer #(
            .IMG_WIDTH (IMG_WIDTH)
        ) u_line_buffer (
            .clk     (clk),
            .wr_en   (accept && (wr_idx == buf_idx_t'(b))),
            .wr_data (in_pixel),
            .wr_col  (wr_col),
            .rd_col  (rd_col),
            .rd_data (row_data[b])
        );
    end

    // Read FSM state register.
    // NOTE: every clocked block uses non-blocking assignments so all registers
    // update together from values sampled at the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Start a row once three full lines are held; issue one read per cycle
    // and release the top line after the last window of the row.
    // NOTE: every output of this block is given a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        rd_issue   = 1'b0;
        rd_last    = 1'b0;
        case (state)
            IDLE: begin
                if (fill >= CNT_W'(3 * IMG_WIDTH)) next_state = RD;
            end
            RD: begin
                rd_issue = 1'b1;
                if (rd_col == COL_W'(IMG_WIDTH - 3)) begin
                    rd_last    = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Write position: column advances per accepted beat, buffer rotates per line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_col <= '0;
            wr_idx <= '0;
        end else if (accept) begin
            if (wr_col == COL_W'(IMG_WIDTH - 1)) begin
                wr_col <= '0;
                wr_idx <= wr_idx + buf_idx_t'(1);
            end else begin
                wr_col <= wr_col + COL_W'(1);
            end
        end
    end

    // Read position: column advances per issued read, top buffer rotates per row.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_col <= '0;
            rd_idx <= '0;
        end else if (rd_last) begin
            rd_col <= '0;
            rd_idx <= rd_idx + buf_idx_t'(1);
        end else if (rd_issue) begin
            rd_col <= rd_col + COL_W'(1);
        end
    end

    // Pixels held: up one per accepted beat, down one line per row release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fill <= '0;
        end else begin
            fill <= fill + CNT_W'(accept) - (rd_last ? CNT_W'(IMG_WIDTH) : CNT_W'(0));
        end
    end

    // Stack the three buffers starting at rd_idx into top/middle/bottom rows.
    always_comb begin
        win_next = '0;
        win_next[ROW_TOP_OFS*PIX_W +: ROW_W] = row_data[rd_idx];
        win_next[ROW_MID_OFS*PIX_W +: ROW_W] = row_data[rd_idx + buf_idx_t'(1)];
        win_next[ROW_BOT_OFS*PIX_W +: ROW_W] = row_data[rd_idx + buf_idx_t'(2)];
    end

    // Register the window; data holds between reads, the row pulse rides
    // alongside the row's last window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pixel_data       <= '0;
            pixel_data_valid <= 1'b0;
            line_done_intr   <= 1'b0;
        end else begin
            pixel_data_valid <= rd_issue;
            line_done_intr   <= rd_last;
            if (rd_issue) begin
                pixel_data <= win_next;
            end
        end
    end

endmodule

// File: tb/tb_image_window_ctrl.sv
// Self-checking bench for image_window_ctrl with IMG_WIDTH=8. A monitor
// rebuilds every expected window from the log of accepted pixels (row r,
// column c of the output image) and checks the handshake and fill count;
// a stimulus table and hand sequences cover the directed corner cases, and a
// random phase exercises gaps in the input stream.
module tb_image_window_ctrl;

    localparam int W   = 8;
    localparam int WPR = W - 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_pixel = '0;
    logic        in_pixel_valid = 1'b0;
    logic        in_ready;
    logic [71:0] pixel_data;
    logic        pixel_data_valid;
    logic        line_done_intr;

    image_window_ctrl #(
        .IMG_WIDTH (W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_pixel         (in_pixel),
        .in_pixel_valid   (in_pixel_valid),
        .in_ready         (in_ready),
        .pixel_data       (pixel_data),
        .pixel_data_valid (pixel_data_valid),
        .line_done_intr   (line_done_intr)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Model state: pixels accepted since reset and windows observed since reset.
    byte unsigned pix_log[$];
    logic [71:0]  win_q[$];
    int acc_cnt = 0;
    int rows_done = 0;
    int first_valid_cyc = -1;
    int e0_cyc = -1;
    logic prev_intr = 1'b0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [71:0] pack9(input int b0, input int b1, input int b2,
                                          input int b3, input int b4, input int b5,
                                          input int b6, input int b7, input int b8);
        int b[9];
        logic [71:0] res;
        b = '{b0, b1, b2, b3, b4, b5, b6, b7, b8};
        res = '0;
        for (int i = 0; i < 9; i++) res[i*8 +: 8] = 8'(b[i]);
        return res;
    endfunction

    // Window w of the output image: row w/WPR, column w%WPR, rows taken from
    // three consecutive input lines.
    function automatic logic [71:0] model_win(input int w);
        int r;
        int c;
        logic [71:0] res;
        r = w / WPR;
        c = w % WPR;
        res = '0;
        for (int row = 0; row < 3; row++)
            for (int k = 0; k < 3; k++)
                res[(row*3 + k)*8 +: 8] = pix_log[(r + row)*W + c + k];
        return res;
    endfunction

    // Monitor, sampling 1 time unit after each rising edge.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (!rst_n) begin
            check("rst_pixel_data", pixel_data, 72'd0);
            check("rst_valid", pixel_data_valid, 1'b0);
            check("rst_intr", line_done_intr, 1'b0);
            check("rst_in_ready", in_ready, 1'b1);
            check("rst_fill", dut.fill, 0);
            rows_done = 0;
            win_q.delete();
            first_valid_cyc = -1;
            prev_intr = 1'b0;
        end else begin
            if (line_done_intr) rows_done++;
            check("fill", dut.fill, acc_cnt - W*rows_done);
            check("in_ready", in_ready, (acc_cnt - W*rows_done) < 4*W);
            if (prev_intr) check("gap_after_row", pixel_data_valid, 1'b0);
            if (pixel_data_valid) begin
                int w;
                int need;
                w = win_q.size();
                need = (w/WPR + 2)*W + (w % WPR) + 3;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                check("window_lines_present", pix_log.size() >= need, 1'b1);
                if (pix_log.size() >= need) check("window", pixel_data, model_win(w));
                check("row_done_pulse", line_done_intr, (w % WPR) == WPR - 1);
                win_q.push_back(pixel_data);
            end else begin
                check("intr_without_valid", line_done_intr, 1'b0);
            end
            prev_intr = line_done_intr;
        end
    end

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        in_pixel_valid = 1'b0;
        pix_log.delete();
        acc_cnt = 0;
        e0_cyc = -1;
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_pixel_valid = 1'b0;
        end
    endtask

    // Present one pixel until it is accepted (bounded); count refused cycles.
    task automatic send_beat(input logic [7:0] d, output int refused);
        refused = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            in_pixel = d;
            in_pixel_valid = 1'b1;
            if (in_ready) begin
                pix_log.push_back(d);
                acc_cnt++;
                if (acc_cnt == 3*W) e0_cyc = cyc + 1;
                break;
            end
            refused++;
        end
    endtask

    task automatic run_stream(input int base, input int n, input bit gaps, output int refused_total);
        int r;
        refused_total = 0;
        for (int i = 0; i < n; i++) begin
            send_beat(8'(base + i), r);
            refused_total += r;
            if (gaps) idle(1);
        end
        idle(1);
    endtask

    typedef struct {
        int          base;
        int          n;
        bit          gaps;
        int          exp_wins;
        int          k;
        logic [71:0] exp_k;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int refused;
        int lines;
        int exp_total;

        tbl[0] = '{0, 24, 1'b0, 6, 0, pack9(0, 1, 2, 8, 9, 10, 16, 17, 18)};
        tbl[1] = '{0, 24, 1'b0, 6, 5, pack9(5, 6, 7, 13, 14, 15, 21, 22, 23)};
        tbl[2] = '{0, 40, 1'b0, 18, 12, pack9(16, 17, 18, 24, 25, 26, 32, 33, 34)};
        tbl[3] = '{0, 24, 1'b1, 6, 0, pack9(0, 1, 2, 8, 9, 10, 16, 17, 18)};

        do_reset(2);

        for (int v = 0; v < 4; v++) begin
            do_reset(2);
            run_stream(tbl[v].base, tbl[v].n, tbl[v].gaps, refused);
            idle(40);
            check($sformatf("win_count[%0d]", v), win_q.size(), tbl[v].exp_wins);
            if (win_q.size() > tbl[v].k)
                check($sformatf("win_k[%0d]", v), win_q[tbl[v].k], tbl[v].exp_k);
            check($sformatf("first_latency[%0d]", v), first_valid_cyc, e0_cyc + 2);
            if (!tbl[v].gaps) check($sformatf("no_refusal[%0d]", v), refused, 0);
        end

        // Reset in the middle of a row, then a fresh frame.
        do_reset(2);
        run_stream(0, 24, 1'b0, refused);
        for (int t = 0; t < 50; t++) begin
            if (win_q.size() >= 3) break;
            idle(1);
        end
        check("third_window_seen", win_q.size() >= 3, 1'b1);
        do_reset(1);
        run_stream(100, 24, 1'b0, refused);
        idle(40);
        check("fresh_win_count", win_q.size(), 6);
        if (win_q.size() > 0)
            check("fresh_first_win", win_q[0], pack9(100, 101, 102, 108, 109, 110, 116, 117, 118));
        check("fresh_latency", first_valid_cyc, e0_cyc + 2);

        // Random data with random gaps; the monitor checks every window.
        do_reset(2);
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 9) < 7) send_beat(8'($urandom), refused);
            else idle(1);
        end
        idle(150);
        lines = acc_cnt / W;
        exp_total = (lines >= 3) ? (lines - 2) * WPR : 0;
        check("random_win_count", win_q.size(), exp_total);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
